mesa_cmd_rx: RTL
================

// Module: mesa_cmd_rx
// PURPOSE
//  - UART receiver and command decoder for the four-table (mesa) motion controller.
//  - Takes serial commands from the embedded host and drives registered per-table Left/Right/Off levels.
//  - Those levels feed the table output stage that produces the M1L..M4O pins.
//  - Includes a link watchdog that forces every table to Off when the host goes silent.
// PARAMETERS
//  CLK_HZ    50_000_000  system clock frequency, Hz
//  BAUD      9600        serial bit rate; DIV = CLK_HZ/BAUD (integer division), DIV >= 4 required
//  WDOG_CYC  50_000_000  clocks without an accepted command before forced Off; 0 disables the watchdog
// PORTS
//  clk        in   1  system clock; all logic rising-edge
//  rst_n      in   1  asynchronous active-low reset
//  rx         in   1  UART line, idle high, asynchronous to clk
//  m_l        out  4  bit i = table i+1 moving Left
//  m_r        out  4  bit i = table i+1 moving Right
//  m_o        out  4  bit i = table i+1 Off/stopped
//  cmd_stb    out  1  1-cycle pulse when a command is accepted
//  frame_err  out  1  1-cycle pulse on bad stop bit, bad sync nibble or (PARITY_EN) parity error
//  wdog_trip  out  1  1-cycle pulse when the watchdog forces all tables Off
//  busy       out  1  high from start-bit confirmation to end of stop-bit sample
// BEHAVIOUR
//  Reset
//   - m_l=0, m_r=0, m_o=4'hF, all pulses 0, busy=0.
//   - FSM=IDLE, watchdog counter=0.
//   - Mid-frame reset aborts the frame silently: no strobe, no error.
//  Input sync
//   - rx passes through a 2-flop synchronizer (reset value 1); a falling edge is detected on the synced value.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE
//   - IDLE: on a falling edge, load bit timer with DIV/2 and go to START.
//   - START: at timer expiry, sample the line.
//     - Line high: glitch; return to IDLE with no error.
//     - Line low: busy=1, reload DIV, go to DATA.
//   - DATA: sample every DIV clocks, 8 bits LSB first, into the shift register.
//   - PARITY (PARITY_EN only): one sample after DIV clocks.
//   - STOP: one sample after DIV clocks, then busy=0 and return to IDLE.
//     - Stop=0: frame_err pulse; byte discarded.
//  Decode (registered, in the cycle after the stop sample)
//   - byte[7:6] = table index T (0..3); byte[5:2] must equal 4'b1010, else frame_err and discard.
//   - byte[1:0] = 00: table T Off.
//   - byte[1:0] = 01: table T Left.
//   - byte[1:0] = 10: table T Right.
//   - byte[1:0] = 11: broadcast, all four tables Off (T ignored).
//   - Outputs change in the cycle after decode; cmd_stb pulses in that same cycle.
//   - Stop-sample to output change = 2 clocks.
//  Output invariant
//   - For every i, exactly one of m_l[i], m_r[i], m_o[i] is 1, in every cycle including reset.
//   - Left->Right reversal is applied directly; dead-time insertion is the output stage's job.
//   - Untargeted tables hold their state.
//  Watchdog
//   - Counter clears on every cmd_stb and otherwise increments, saturating at WDOG_CYC-1.
//   - When it reaches WDOG_CYC-1: m_o=4'hF, m_l=m_r=0, one wdog_trip pulse. No retrip until a command clears it.
//   - If cmd_stb and expiry fall in the same cycle, the command wins: counter clears and no trip occurs.
//   - WDOG_CYC=0: counter held at 0, wdog_trip never asserts.
//  Rejected frames
//   - A rejected frame never resets the watchdog and never changes m_*.
// CONFIGURATION
//  PARITY_EN
//   - Defined: frame is 8E1. The parity bit is sampled after data bit 7.
//   - Defined: a mismatch with even parity over byte[7:0] gives frame_err and the byte is discarded.
//   - Not defined: frame is 8N1 with no PARITY state. Port list is identical in both builds.
// TESTING  (CLK_HZ=1_000_000, BAUD=100_000 -> DIV=10, WDOG_CYC=2000)
//  1. Reset, rx=1 held -> m_o=4'hF, m_l=m_r=0, no pulses, busy=0.
//  2. Send 0x69 (T=1, Left) -> cmd_stb once; m_l=4'b0010, m_o=4'b1101, exactly 2 clk after stop sample.
//  3. Send 0xEA then 0x2B -> table 4 Right (m_r=4'b1000); then broadcast -> m_o=4'hF.
//  4. Send 0x29 with stop bit forced 0, and 0x45 (bad sync nibble) -> frame_err each time; m_* unchanged, no cmd_stb.
//  5. Pulse rx low for 3 clk only -> no busy, no error.
//     Then assert rst_n=0 during data bit 4 of 0x69 -> outputs back to reset values, no cmd_stb.
//  6. Send 0x69, idle 2000 clk -> wdog_trip once, m_o=4'hF.
//     Repeat with a new command accepted on the expiry cycle -> no trip.
//     With PARITY_EN, a wrong parity bit -> frame_err only.

Source files
------------

// File: rtl/mesa_cmd_rx.sv
// mesa_cmd_rx: UART receiver and command decoder for the four-table motion
// controller. Each accepted byte drives registered per-table Left/Right/Off
// levels. A link watchdog forces every table Off when the host goes silent.
// Optional build macro PARITY_EN: frames are 8E1 and parity errors are rejected.
// Without it, frames are 8N1. The port list is the same in both builds.
module mesa_cmd_rx #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int WDOG_CYC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [3:0] m_l,
    output logic [3:0] m_r,
    output logic [3:0] m_o,
    output logic       cmd_stb,
    output logic       frame_err,
    output logic       wdog_trip,
    output logic       busy
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int TW  = $clog2(DIV + 1);
    localparam logic [TW-1:0] T_FULL = TW'(DIV);
    localparam logic [TW-1:0] T_HALF = TW'(DIV / 2);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam int WW = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WW-1:0] W_MAX = WW'((WDOG_CYC > 0) ? WDOG_CYC - 1 : 0);
    localparam logic [3:0] SYNC_NIB  = 4'b1010;
    localparam logic [1:0] CMD_OFF   = 2'b00;
    localparam logic [1:0] CMD_LEFT  = 2'b01;
    localparam logic [1:0] CMD_RIGHT = 2'b10;
    localparam logic [1:0] CMD_ALL   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

`ifdef PARITY_EN
    // Even parity: the transmitted bit makes the 9-bit total even.
    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic          rx_meta_r, rx_sync_r, rx_prev_r;
    logic          fall_s, tick_s;
    state_t        state_r, state_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [2:0]    bit_cnt_r, bit_cnt_s;
    logic [7:0]    shift_r, shift_s;
    logic          busy_r, busy_s;
    logic          ok_r, ok_s, bad_r, bad_s;
`ifdef PARITY_EN
    logic          par_err_r, par_err_s;
`endif
    logic          dec_vld_r, frame_err_r;
    logic [1:0]    dec_tbl_r, dec_cmd_r;
    logic [3:0]    m_l_r, m_r_r, m_o_r, l_s, r_s, o_s;
    logic          cmd_stb_r, stb_s, wdog_trip_r, trip_s;
    logic [WW-1:0] wdog_cnt_r, cnt_s;
    logic          armed_r, armed_s;

    assign fall_s = rx_prev_r & ~rx_sync_r;
    assign tick_s = (timer_r == T_ONE);

    // Two-flop synchronizer on the asynchronous line plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Frame FSM next-state logic: bit timing, sampling and frame verdict.
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        busy_s    = busy_r;
        ok_s      = 1'b0;
        bad_s     = 1'b0;
`ifdef PARITY_EN
        par_err_s = par_err_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (fall_s) begin
                    timer_s = T_HALF;
                    state_s = S_START;
                end else begin
                    timer_s = timer_r;
                end
            end
            S_START: begin
                if (!tick_s) begin
                    timer_s = timer_r - T_ONE;
                end else if (rx_sync_r) begin
                    state_s = S_IDLE;            // glitch, not a start bit
                end else begin
                    busy_s    = 1'b1;
                    timer_s   = T_FULL;
                    bit_cnt_s = 3'd0;
`ifdef PARITY_EN
                    par_err_s = 1'b0;
`endif
                    state_s   = S_DATA;
                end
            end
            S_DATA: begin
                if (!tick_s) begin
                    timer_s = timer_r - T_ONE;
                end else begin
                    shift_s = {rx_sync_r, shift_r[7:1]};
                    timer_s = T_FULL;
                    if (bit_cnt_r == 3'd7) begin
`ifdef PARITY_EN
                        state_s = S_PARITY;
`else
                        state_s = S_STOP;
`endif
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end
            end
`ifdef PARITY_EN
            S_PARITY: begin
                if (!tick_s) begin
                    timer_s = timer_r - T_ONE;
                end else begin
                    par_err_s = (rx_sync_r != even_par(shift_r));
                    timer_s   = T_FULL;
                    state_s   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!tick_s) begin
                    timer_s = timer_r - T_ONE;
                end else begin
                    busy_s  = 1'b0;
                    state_s = S_IDLE;
`ifdef PARITY_EN
                    if (rx_sync_r && !par_err_r) begin
`else
                    if (rx_sync_r) begin
`endif
                        ok_s = 1'b1;
                    end else begin
                        bad_s = 1'b1;
                    end
                end
            end
            default: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            timer_r   <= '0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            busy_r    <= 1'b0;
            ok_r      <= 1'b0;
            bad_r     <= 1'b0;
`ifdef PARITY_EN
            par_err_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            busy_r    <= busy_s;
            ok_r      <= ok_s;
            bad_r     <= bad_s;
`ifdef PARITY_EN
            par_err_r <= par_err_s;
`endif
        end
    end

    // Decode stage: validate the sync nibble and latch table/command fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_vld_r   <= 1'b0;
            frame_err_r <= 1'b0;
            dec_tbl_r   <= 2'd0;
            dec_cmd_r   <= 2'd0;
        end else begin
            dec_vld_r   <= ok_r && (shift_r[5:2] == SYNC_NIB);
            frame_err_r <= bad_r || (ok_r && (shift_r[5:2] != SYNC_NIB));
            dec_tbl_r   <= shift_r[7:6];
            dec_cmd_r   <= shift_r[1:0];
        end
    end

    // Next table levels and watchdog: an accepted command has priority over expiry.
    always_comb begin
        l_s     = m_l_r;
        r_s     = m_r_r;
        o_s     = m_o_r;
        stb_s   = 1'b0;
        trip_s  = 1'b0;
        cnt_s   = wdog_cnt_r;
        armed_s = armed_r;
        if (dec_vld_r) begin
            stb_s   = 1'b1;
            cnt_s   = '0;
            armed_s = 1'b1;
            case (dec_cmd_r)
                CMD_OFF: begin
                    l_s[dec_tbl_r] = 1'b0;
                    r_s[dec_tbl_r] = 1'b0;
                    o_s[dec_tbl_r] = 1'b1;
                end
                CMD_LEFT: begin
                    l_s[dec_tbl_r] = 1'b1;
                    r_s[dec_tbl_r] = 1'b0;
                    o_s[dec_tbl_r] = 1'b0;
                end
                CMD_RIGHT: begin
                    l_s[dec_tbl_r] = 1'b0;
                    r_s[dec_tbl_r] = 1'b1;
                    o_s[dec_tbl_r] = 1'b0;
                end
                CMD_ALL: begin
                    l_s = 4'h0;
                    r_s = 4'h0;
                    o_s = 4'hF;
                end
                default: begin
                    l_s = 4'h0;
                    r_s = 4'h0;
                    o_s = 4'hF;
                end
            endcase
        end else if (WDOG_CYC == 0) begin
            cnt_s = '0;
        end else if (wdog_cnt_r == W_MAX) begin
            if (armed_r) begin
                trip_s  = 1'b1;
                armed_s = 1'b0;
                l_s     = 4'h0;
                r_s     = 4'h0;
                o_s     = 4'hF;
            end else begin
                cnt_s = wdog_cnt_r;          // saturated, already tripped
            end
        end else begin
            cnt_s = wdog_cnt_r + WW'(1);
        end
    end

    // Registered outputs, pulses and watchdog state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_l_r       <= 4'h0;
            m_r_r       <= 4'h0;
            m_o_r       <= 4'hF;
            cmd_stb_r   <= 1'b0;
            wdog_trip_r <= 1'b0;
            wdog_cnt_r  <= '0;
            armed_r     <= 1'b1;
        end else begin
            m_l_r       <= l_s;
            m_r_r       <= r_s;
            m_o_r       <= o_s;
            cmd_stb_r   <= stb_s;
            wdog_trip_r <= trip_s;
            wdog_cnt_r  <= cnt_s;
            armed_r     <= armed_s;
        end
    end

    assign m_l       = m_l_r;
    assign m_r       = m_r_r;
    assign m_o       = m_o_r;
    assign cmd_stb   = cmd_stb_r;
    assign frame_err = frame_err_r;
    assign wdog_trip = wdog_trip_r;
    assign busy      = busy_r;

endmodule
